// File: rtl/wifi_tx_mapper_ctrl.sv
// wifi_tx_mapper_ctrl
// Frame controller in front of a QPSK mapper. It collects coded bits in
// pairs, hands each completed pair to the mapper with its subcarrier and
// symbol index, and inserts a fixed idle slot between OFDM symbols so the
// CP/IFFT stage downstream has time to drain the previous symbol.
module wifi_tx_mapper_ctrl #(
  parameter int N_SC = 48,
  parameter int GAP  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_sym,
  input  logic       abort,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       map_valid,
  output logic [1:0] map_data,
  output logic [5:0] sc_idx,
  output logic [7:0] sym_idx,
  output logic       last_sc,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_GAP     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [5:0] SC_LAST  = 6'(N_SC - 1);
  localparam logic [7:0] GAP_INIT = 8'(GAP - 1);

  // Control state
  state_t      state_q,     state_d;
  logic [7:0]  num_sym_q,   num_sym_d;
  logic        phase_q,     phase_d;
  logic [5:0]  sc_cnt_q,    sc_cnt_d;
  logic [7:0]  sym_cnt_q,   sym_cnt_d;
  logic [7:0]  gap_cnt_q,   gap_cnt_d;

  // Half-pair holding bit; pure data, never needs a reset value
  logic        first_q,     first_d;

  // Registered outputs
  logic        map_valid_q, map_valid_d;
  logic [1:0]  map_data_q,  map_data_d;
  logic [5:0]  sc_idx_q,    sc_idx_d;
  logic [7:0]  sym_idx_q,   sym_idx_d;
  logic        last_sc_q,   last_sc_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic        bit_accept;

  // True when the pair counter sits on the final subcarrier of a symbol
  function automatic logic is_last_sc(input logic [5:0] cnt);
    return (cnt == SC_LAST);
  endfunction

  // True when the symbol counter sits on the final symbol of the frame
  function automatic logic is_last_sym(input logic [7:0] cnt, input logic [7:0] total);
    return (cnt == (total - 8'd1));
  endfunction

  assign bit_ready  = (state_q == ST_COLLECT);
  assign bit_accept = bit_valid & bit_ready;

  // Next-state and next-output decode for the whole controller
  always_comb begin
    state_d     = state_q;
    num_sym_d   = num_sym_q;
    phase_d     = phase_q;
    sc_cnt_d    = sc_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    first_d     = first_q;
    map_valid_d = 1'b0;
    map_data_d  = map_data_q;
    sc_idx_d    = sc_idx_q;
    sym_idx_d   = sym_idx_q;
    last_sc_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_sym != 8'd0) begin
            num_sym_d = num_sym;
            sc_cnt_d  = 6'd0;
            sym_cnt_d = 8'd0;
            phase_d   = 1'b0;
            sc_idx_d  = 6'd0;
            sym_idx_d = 8'd0;
            state_d   = ST_COLLECT;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end

      ST_COLLECT: begin
        if (bit_accept) begin
          if (!phase_q) begin
            first_d = bit_in;
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            map_valid_d = 1'b1;
            map_data_d  = {first_q, bit_in};
            sc_idx_d    = sc_cnt_q;
            sym_idx_d   = sym_cnt_q;
            if (is_last_sc(sc_cnt_q)) begin
              last_sc_d = 1'b1;
              sc_cnt_d  = 6'd0;
              if (is_last_sym(sym_cnt_q, num_sym_q)) begin
                state_d = ST_DONE;
              end else begin
                state_d   = ST_GAP;
                sym_cnt_d = sym_cnt_q + 8'd1;
                gap_cnt_d = GAP_INIT;
              end
            end else begin
              sc_cnt_d = sc_cnt_q + 6'd1;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_COLLECT;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything decided above: drop the half pair and
    // suppress any pair that would have completed this cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      phase_d     = 1'b0;
      map_valid_d = 1'b0;
      map_data_d  = map_data_q;
      sc_idx_d    = sc_idx_q;
      sym_idx_d   = sym_idx_q;
      last_sc_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    // done is taken from the DONE state itself, so it lands one cycle after
    // the final pair of the frame (and one cycle after a zero-symbol start).
    done_d = (state_q == ST_DONE) && !abort;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      num_sym_q   <= 8'd0;
      phase_q     <= 1'b0;
      sc_cnt_q    <= 6'd0;
      sym_cnt_q   <= 8'd0;
      gap_cnt_q   <= 8'd0;
      map_valid_q <= 1'b0;
      map_data_q  <= 2'd0;
      sc_idx_q    <= 6'd0;
      sym_idx_q   <= 8'd0;
      last_sc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_sym_q   <= num_sym_d;
      phase_q     <= phase_d;
      sc_cnt_q    <= sc_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      map_valid_q <= map_valid_d;
      map_data_q  <= map_data_d;
      sc_idx_q    <= sc_idx_d;
      sym_idx_q   <= sym_idx_d;
      last_sc_q   <= last_sc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Half-pair bit register
  always_ff @(posedge clk) begin
    first_q <= first_d;
  end

  assign map_valid = map_valid_q;
  assign map_data  = map_data_q;
  assign sc_idx    = sc_idx_q;
  assign sym_idx   = sym_idx_q;
  assign last_sc   = last_sc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wifi_tx_mapper_ctrl.sv
// Directed bench for wifi_tx_mapper_ctrl: whole frames, bursty input,
// zero-length frames, abort and mid-frame reset.
module tb_wifi_tx_mapper_ctrl;

  localparam int N_SC = 48;
  localparam int GAP  = 16;
  localparam int LOGN = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_sym = 8'd0;
  logic       abort = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_ready;
  logic       map_valid;
  logic [1:0] map_data;
  logic [5:0] sc_idx;
  logic [7:0] sym_idx;
  logic       last_sc;
  logic       busy;
  logic       done;

  wifi_tx_mapper_ctrl #(.N_SC(N_SC), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .num_sym(num_sym),
    .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .map_valid(map_valid), .map_data(map_data),
    .sc_idx(sc_idx), .sym_idx(sym_idx), .last_sc(last_sc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus controls written by the main sequence only
  int mode   = 0;   // 0: bits 1,0,1,0...  1: pair k carries k%4
  bit toggle = 1'b0;

  // Bit source: presents the next bit of the frame on every falling edge
  initial begin : driver
    int bit_j;
    int tcnt;
    bit_j = 0;
    tcnt  = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      if (!busy) bit_j = 0;
      bit_valid = toggle ? tcnt[0] : 1'b1;
      if (mode == 0) bit_in = ~bit_j[0];
      else           bit_in = bit_j[0] ? bit_j[1] : bit_j[2];
      if (bit_valid && bit_ready) bit_j++;
    end
  end

  // Output logs written by the monitor only
  logic [5:0] log_sc   [LOGN];
  logic [7:0] log_sym  [LOGN];
  logic [1:0] log_data [LOGN];
  logic       log_last [LOGN];
  int         gap_log  [LOGN];
  int mv_n = 0, gap_n = 0, done_n = 0, hold_bad = 0;
  int cyc = 0, last_cyc = 0, done_cyc = 0;

  // Monitor: samples outputs on the falling edge
  initial begin : monitor
    int  run;
    logic [1:0] prev_data;
    logic prev_rst;
    run = 0;
    prev_data = 2'd0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (map_valid === 1'b1) begin
        if (mv_n < LOGN) begin
          log_sc[mv_n]   = sc_idx;
          log_sym[mv_n]  = sym_idx;
          log_data[mv_n] = map_data;
          log_last[mv_n] = last_sc;
        end
        mv_n++;
      end
      if (last_sc === 1'b1) last_cyc = cyc;
      if (done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
      end
      if (reset && prev_rst && (map_valid !== 1'b1) && (map_data !== prev_data)) hold_bad++;
      prev_data = map_data;
      prev_rst  = reset;
      if (busy !== 1'b1) run = 0;
      else if (bit_ready !== 1'b1) run++;
      else if (run > 0) begin
        if (gap_n < LOGN) gap_log[gap_n] = run;
        gap_n++;
        run = 0;
      end
    end
  end

  task automatic start_frame(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    num_sym = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while ((done !== 1'b1) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_done_seen"}, done, 1);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
  endtask

  // Compare logged pulses of one frame against the index/data model
  task automatic check_frame(input string tag, input int m0, input int nsym, input int dmode);
    int cnt, exp_sc, exp_sym, exp_dat;
    cnt = mv_n - m0;
    check_eq({tag, "_pulses"}, cnt, N_SC * nsym);
    for (int k = 0; k < cnt && k < N_SC * nsym; k++) begin
      exp_sc  = k % N_SC;
      exp_sym = k / N_SC;
      exp_dat = (dmode == 0) ? 2 : (k % 4);
      check_eq({tag, "_sc_idx"}, log_sc[m0 + k], exp_sc);
      check_eq({tag, "_sym_idx"}, log_sym[m0 + k], exp_sym);
      check_eq({tag, "_map_data"}, log_data[m0 + k], exp_dat);
      check_eq({tag, "_last_sc"}, log_last[m0 + k], (exp_sc == N_SC - 1) ? 1 : 0);
    end
  endtask

  task automatic check_gaps(input string tag, input int g0, input int nsym);
    check_eq({tag, "_gap_count"}, gap_n - g0, nsym - 1);
    for (int g = g0; g < gap_n && g < LOGN; g++) check_eq({tag, "_gap_len"}, gap_log[g], GAP);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_map_valid"}, map_valid, 0);
    check_eq({tag, "_map_data"}, map_data, 0);
    check_eq({tag, "_sc_idx"}, sc_idx, 0);
    check_eq({tag, "_sym_idx"}, sym_idx, 0);
    check_eq({tag, "_last_sc"}, last_sc, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_bit_ready"}, bit_ready, 0);
  endtask

  initial begin : main
    int m0, d0, g0, i;

    // Power-on reset
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_bit_ready", bit_ready, 0);

    // One symbol, bits 1,0 repeated, plus a start while busy
    mode = 0; toggle = 1'b0;
    m0 = mv_n; d0 = done_n; g0 = gap_n;
    start_frame(8'd1);
    check_eq("t1_busy", busy, 1);
    repeat (10) @(negedge clk);
    start = 1'b1; num_sym = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1", 400);
    check_frame("t1", m0, 1, 0);
    check_eq("t1_done_count", done_n - d0, 1);
    check_eq("t1_done_after_last", done_cyc - last_cyc, 1);
    check_gaps("t1", g0, 1);
    repeat (10) @(negedge clk);
    check_eq("t1_ignored_start_pulses", mv_n - m0, N_SC);
    check_eq("t1_ignored_start_busy", busy, 0);

    // Three symbols, continuous, varying pair values
    mode = 1;
    m0 = mv_n; d0 = done_n; g0 = gap_n;
    start_frame(8'd3);
    wait_done("t2", 1000);
    check_frame("t2", m0, 3, 1);
    check_gaps("t2", g0, 3);
    check_eq("t2_done_count", done_n - d0, 1);

    // Two symbols with bit_valid toggling every cycle
    mode = 0; toggle = 1'b1;
    m0 = mv_n; d0 = done_n; g0 = gap_n;
    start_frame(8'd2);
    wait_done("t3", 1000);
    check_frame("t3", m0, 2, 0);
    check_gaps("t3", g0, 2);
    check_eq("t3_done_count", done_n - d0, 1);
    toggle = 1'b0;

    // Zero-symbol frame
    m0 = mv_n; d0 = done_n;
    start_frame(8'd0);
    check_eq("t4_done_early", done, 0);
    check_eq("t4_busy_in_done", busy, 1);
    @(negedge clk);
    check_eq("t4_done", done, 1);
    check_eq("t4_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("t4_pulses", mv_n - m0, 0);
    check_eq("t4_done_count", done_n - d0, 1);

    // Abort after three accepted bits of symbol 0
    mode = 0;
    m0 = mv_n; d0 = done_n;
    start_frame(8'd1);
    i = 0;
    while ((map_valid !== 1'b1) && (i < 20)) begin
      @(negedge clk);
      i++;
    end
    check_eq("t5_first_pair_seen", map_valid, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_busy_after_abort", busy, 0);
    check_eq("t5_map_valid_after_abort", map_valid, 0);
    check_eq("t5_bit_ready_after_abort", bit_ready, 0);
    repeat (20) @(negedge clk);
    check_eq("t5_pulses", mv_n - m0, 1);
    check_eq("t5_done_count", done_n - d0, 0);
    check_eq("t5_pair_data", log_data[m0], 2);
    check_eq("t5_pair_sc", log_sc[m0], 0);
    m0 = mv_n; d0 = done_n;
    start_frame(8'd1);
    wait_done("t5r", 400);
    check_frame("t5r", m0, 1, 0);
    check_eq("t5r_done_count", done_n - d0, 1);

    // Reset in the middle of symbol 1, then a clean one-symbol frame
    mode = 1;
    start_frame(8'd2);
    i = 0;
    while (!((map_valid === 1'b1) && (sym_idx === 8'd1)) && (i < 400)) begin
      @(negedge clk);
      i++;
    end
    check_eq("t6_reached_sym1", sym_idx, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("t6_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m0 = mv_n; d0 = done_n; g0 = gap_n;
    start_frame(8'd1);
    wait_done("t6r", 400);
    check_frame("t6r", m0, 1, 1);
    check_eq("t6r_done_count", done_n - d0, 1);
    check_gaps("t6r", g0, 1);

    check_eq("map_data_hold", hold_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wifi_tx_mapper_ctrl.md
WIFI_TX_MAPPER_CTRL -- requirements
Module: wifi_tx_mapper_ctrl

Interface
REQ-001 SHALL have parameter N_SC, default 48: data subcarriers per OFDM symbol, range 2..63.
REQ-002 SHALL have parameter GAP, default 16: idle cycles between symbols (CP/IFFT slot), range 1..255.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port num_sym  input  8  OFDM symbols in frame; sampled on accepted start.
REQ-007 SHALL have port abort  input  1  synchronous frame abort.
REQ-008 SHALL have port bit_valid  input  1  coded bit available.
REQ-009 SHALL have port bit_in  input  1  coded bit.
REQ-010 SHALL have port bit_ready  output  1  controller accepts bit this cycle.
REQ-011 SHALL have port map_valid  output  1  drives QPSK mapper valid_in.
REQ-012 SHALL have port map_data  output  2  drives QPSK mapper data_in.
REQ-013 SHALL have port sc_idx  output  6  subcarrier index of current map_valid pair.
REQ-014 SHALL have port sym_idx  output  8  symbol index of current map_valid pair.
REQ-015 SHALL have port last_sc  output  1  high with final pair of each symbol.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-018 SHALL implement states IDLE, COLLECT, GAP, DONE; all outputs registered except bit_ready, which is decoded from state only.
REQ-019 IDLE: start=1 with num_sym>0 SHALL latch num_sym, clear sc_idx/sym_idx/phase, go COLLECT next cycle.
REQ-020 IDLE: start=1 with num_sym=0 SHALL go DONE directly, producing no map_valid.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 bit_ready SHALL be 1 only in COLLECT; a bit is accepted when bit_valid&bit_ready.
REQ-023 First accepted bit of a pair SHALL be held internally; second accepted bit SHALL produce, next cycle, map_valid=1 for exactly one cycle with map_data={first,second}.
REQ-024 map_valid SHALL be 0 in every cycle without a completed pair; map_data SHALL hold its last value when map_valid=0.
REQ-025 sc_idx SHALL equal 0..N_SC-1 for successive pairs within a symbol and wrap to 0 at the next symbol.
REQ-026 Pair with sc_idx=N_SC-1 SHALL assert last_sc in the same cycle as its map_valid.
REQ-027 On accepting the final bit of a symbol: if sym_idx=latched num_sym-1, go DONE; else go GAP and increment sym_idx (visible from the next symbol's first pair).
REQ-028 GAP SHALL last exactly GAP cycles with bit_ready=0, then return to COLLECT.
REQ-029 DONE SHALL last one cycle with done=1, then go IDLE.
REQ-030 bit_valid gaps in COLLECT SHALL stall without loss; half-pair state retained indefinitely.
REQ-031 abort=1 in any non-IDLE state SHALL go IDLE next cycle, discard any half pair, assert no done and no further map_valid; abort has priority over start and bit acceptance.
REQ-032 In a frame, map_valid count SHALL equal N_SC*num_sym exactly.

Reset
REQ-033 reset=0 SHALL immediately force IDLE and map_valid, map_data, sc_idx, sym_idx, last_sc, busy, done, phase, latched num_sym to 0.
REQ-034 Reset mid-frame SHALL discard all progress; first post-reset start begins a fresh frame at sc_idx=0, sym_idx=0.

Verification
REQ-035 start, num_sym=1, continuous bits 1,0 repeated -> 48 map_valid pulses, map_data=2'b10, sc_idx 0..47, last_sc on 48th, done 1 cycle later, busy low after.
REQ-036 num_sym=3, continuous bits -> 144 pulses, sym_idx 0/1/2, exactly 16 bit_ready=0 cycles between symbols, single done.
REQ-037 num_sym=2, bit_valid toggling every cycle -> same pair values and counts as continuous case, no lost bits.
REQ-038 start with num_sym=0 -> done after 1 cycle, zero map_valid; start during busy -> ignored, count unchanged.
REQ-039 abort after 3 bits of symbol 0 -> exactly 1 map_valid, IDLE next cycle, no done; new start restarts at sc_idx=0.
REQ-040 reset asserted mid-symbol 1 -> all outputs 0 same cycle; post-reset frame of 1 symbol completes normally.
